// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the sample/impulse memory scheduler.
package mem_sched_pkg;

    // Frame sequencing states
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        COEF,
        SAMP,
        DONE
    } state_t;

    // Tap word layout: delay increment in the high byte, gain in the low byte
    localparam int DELAY_MSB = 15;
    localparam int DELAY_LSB = 8;
    localparam int GAIN_MSB  = 7;
    localparam int GAIN_LSB  = 0;

    // Last address of the sample ring
    localparam logic [15:0] RING_TOP = 16'hFFFF;

endpackage

// File: rtl/ring_addr_sub.sv
// Combinational ring address: steps back cum_delay samples from newest,
// wrapping inside [buf_base, top of memory], and flags delays that do not fit.
module ring_addr_sub #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] newest,
    input  logic [ADDR_W:0]   cum_delay,
    input  logic [ADDR_W-1:0] buf_base,
    output logic [ADDR_W-1:0] ring_addr,
    output logic              out_of_range
);

    logic [ADDR_W:0] ring_size;
    logic [ADDR_W:0] diff;
    logic [ADDR_W:0] wrapped;

    // Subtract the delay; fold back by the ring size when it lands below the ring
    always_comb begin
        ring_size    = {1'b1, {ADDR_W{1'b0}}} - {1'b0, buf_base};
        diff         = {1'b0, newest} - cum_delay;
        wrapped      = diff + ring_size;
        out_of_range = (cum_delay >= ring_size);
        if ((cum_delay > {1'b0, newest}) || (diff[ADDR_W-1:0] < buf_base)) begin
            ring_addr = wrapped[ADDR_W-1:0];
        end else begin
            ring_addr = diff[ADDR_W-1:0];
        end
    end

endmodule

// File: rtl/sample_mem_scheduler.sv
// Per-sample memory scheduler: one ring write of the new sample, then a walk of
// the impulse table fetching (delayed sample, gain) pairs for the reverb MAC.
module sample_mem_scheduler
    import mem_sched_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int TAP_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic              record,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [TAP_W-1:0]  num_taps,
    input  logic [ADDR_W-1:0] buf_base,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              tap_valid,
    output logic [DATA_W-1:0] tap_sample,
    output logic [7:0]        tap_gain,
    output logic              frame_done,
    output logic              overrun
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] wp_reg;
    logic [ADDR_W-1:0] newest_reg;
    logic [ADDR_W:0]   cum_delay_reg;
    logic [TAP_W-1:0]  count_reg;
    logic [TAP_W-1:0]  index_reg;
    logic [7:0]        gain_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              tap_valid_reg;
    logic [DATA_W-1:0] tap_sample_reg;
    logic [7:0]        tap_gain_reg;
    logic              overrun_reg;

    logic [ADDR_W-1:0] samp_addr;
    logic              samp_oor;
    logic [ADDR_W-1:0] prev_addr;
    logic              prev_oor;
    logic [ADDR_W-1:0] prev_newest;
    logic [ADDR_W-1:0] write_addr;
    logic [TAP_W:0]    index_inc;

    // Address of the delayed sample for the current tap
    ring_addr_sub #(.ADDR_W(ADDR_W)) u_samp_addr (
        .newest       (newest_reg),
        .cum_delay    (cum_delay_reg),
        .buf_base     (buf_base),
        .ring_addr    (samp_addr),
        .out_of_range (samp_oor)
    );

    // Last written sample (one behind the write pointer) for frames without a write
    ring_addr_sub #(.ADDR_W(ADDR_W)) u_prev_addr (
        .newest       (wp_reg),
        .cum_delay    ((ADDR_W+1)'(1)),
        .buf_base     (buf_base),
        .ring_addr    (prev_addr),
        .out_of_range (prev_oor)
    );

    // A one-slot ring has nowhere else to step back to
    assign prev_newest = prev_oor ? wp_reg : prev_addr;
    // A pointer left below a moved ring base restarts at the base
    assign write_addr  = (wp_reg < buf_base) ? buf_base : wp_reg;
    assign index_inc   = {1'b0, index_reg} + (TAP_W+1)'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and memory port drive; port fields follow registered state only,
    // so they stay put while the memory stalls
    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            IDLE: begin
                if (sample_tick) begin
                    if (record) begin
                        state_next = WRITE;
                    end else if (num_taps == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = COEF;
                    end
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = write_addr;
                mem_wdata = wdata_reg;
                if (mem_ready) begin
                    state_next = (count_reg == '0) ? DONE : COEF;
                end
            end
            COEF: begin
                mem_req  = 1'b1;
                mem_addr = ADDR_W'(index_reg);
                if (mem_ready) begin
                    state_next = SAMP;
                end
            end
            SAMP: begin
                mem_req  = 1'b1;
                mem_addr = samp_addr;
                if (samp_oor) begin
                    state_next = DONE;
                end else if (mem_ready) begin
                    state_next = (index_inc < {1'b0, count_reg}) ? COEF : DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Frame datapath: pointers, tap walk and registered MAC outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_reg         <= buf_base;
            newest_reg     <= '0;
            cum_delay_reg  <= '0;
            count_reg      <= '0;
            index_reg      <= '0;
            gain_reg       <= '0;
            wdata_reg      <= '0;
            tap_valid_reg  <= 1'b0;
            tap_sample_reg <= '0;
            tap_gain_reg   <= '0;
            overrun_reg    <= 1'b0;
        end else begin
            tap_valid_reg <= 1'b0;
            overrun_reg   <= sample_tick && (state_reg != IDLE);
            case (state_reg)
                IDLE: begin
                    if (sample_tick) begin
                        count_reg     <= num_taps;
                        cum_delay_reg <= '0;
                        index_reg     <= '0;
                        wdata_reg     <= sample_in;
                        newest_reg    <= record ? wp_reg : prev_newest;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        newest_reg <= write_addr;
                        wp_reg     <= (write_addr == RING_TOP) ? buf_base : write_addr + 1'b1;
                    end
                end
                COEF: begin
                    if (mem_ready) begin
                        cum_delay_reg <= cum_delay_reg + (ADDR_W+1)'(mem_rdata[DELAY_MSB:DELAY_LSB]);
                        gain_reg      <= mem_rdata[GAIN_MSB:GAIN_LSB];
                    end
                end
                SAMP: begin
                    if (!samp_oor && mem_ready) begin
                        tap_valid_reg  <= 1'b1;
                        tap_sample_reg <= mem_rdata;
                        tap_gain_reg   <= gain_reg;
                        index_reg      <= index_inc[TAP_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tap_valid  = tap_valid_reg;
    assign tap_sample = tap_sample_reg;
    assign tap_gain   = tap_gain_reg;
    assign frame_done = (state_reg == DONE);
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_sample_mem_scheduler.sv
// Directed bench for sample_mem_scheduler with a behavioural memory model.
module tb_sample_mem_scheduler;

    logic        clk;
    logic        rst;
    logic        sample_tick;
    logic        record;
    logic [15:0] sample_in;
    logic [10:0] num_taps;
    logic [15:0] buf_base;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        tap_valid;
    logic [15:0] tap_sample;
    logic [7:0]  tap_gain;
    logic        frame_done;
    logic        overrun;

    sample_mem_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .sample_tick(sample_tick),
        .record     (record),
        .sample_in  (sample_in),
        .num_taps   (num_taps),
        .buf_base   (buf_base),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .tap_valid  (tap_valid),
        .tap_sample (tap_sample),
        .tap_gain   (tap_gain),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: bench preloads take priority over DUT writes
    logic [15:0] mem [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_req && mem_we && mem_ready) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event logs, cycle numbers relative to the tick cycle
    logic [31:0] acc_q [$];
    logic [31:0] wr_q  [$];
    logic [31:0] tap_q [$];
    int          fd_q  [$];
    int          ov_q  [$];

    always begin
        int k;
        @(negedge clk);
        #1;
        k = cyc - t0;
        if (mem_req && mem_ready) begin
            acc_q.push_back({7'd0, mem_we, mem_addr, k[7:0]});
            if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
        end
        if (tap_valid)  tap_q.push_back({k[7:0], tap_sample, tap_gain});
        if (frame_done) fd_q.push_back(k);
        if (overrun)    ov_q.push_back(k);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic chk_acc(input string tag, input int i, input logic we, input logic [15:0] a, input int c);
        logic [31:0] got;
        got = (i < acc_q.size()) ? acc_q[i] : 32'hFFFF_FFFF;
        check(tag, got, {7'd0, we, a, c[7:0]});
    endtask

    task automatic chk_tap(input string tag, input int i, input int c, input logic [15:0] s, input logic [7:0] g);
        logic [31:0] got;
        got = (i < tap_q.size()) ? tap_q[i] : 32'hFFFF_FFFF;
        check(tag, got, {c[7:0], s, g});
    endtask

    task automatic chk_fd(input string tag, input int c);
        check({tag, "_n"}, fd_q.size(), 1);
        if (fd_q.size() > 0) check(tag, fd_q[0], c);
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic do_reset(input logic [15:0] base);
        @(negedge clk);
        rst         = 1'b1;
        buf_base    = base;
        sample_tick = 1'b0;
        mem_ready   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the negedge of tick-relative cycle 1
    task automatic run_tick(input logic rec, input logic [10:0] n, input logic [15:0] s);
        acc_q.delete(); wr_q.delete(); tap_q.delete(); fd_q.delete(); ov_q.delete();
        @(negedge clk);
        t0          = cyc;
        record      = rec;
        num_taps    = n;
        sample_in   = s;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sample_tick = 1'b0; record = 1'b1; sample_in = '0; num_taps = '0;
        buf_base = 16'h0100; mem_ready = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        // Reset state
        do_reset(16'h0100);
        check("rst_flags", {mem_req, mem_we, tap_valid, frame_done, overrun}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_tap", {tap_sample, tap_gain}, 32'h0);

        // Zero taps: single write at buf_base, done in cycle 2, pointer advances
        run_tick(1'b1, 11'd0, 16'h1234); settle(4);
        check("A_nacc", acc_q.size(), 1);
        chk_acc("A_wr", 0, 1'b1, 16'h0100, 1);
        check("A_wdata", (wr_q.size() > 0) ? wr_q[0] : 32'hFFFF_FFFF, {16'h0100, 16'h1234});
        chk_fd("A_fd", 2);
        check("A_ntap", tap_q.size(), 0);
        run_tick(1'b1, 11'd0, 16'h1111); settle(4);
        chk_acc("A2_wr", 0, 1'b1, 16'h0101, 1);

        // Two taps from newest=0x0200
        poke(16'h0000, 16'h0305); poke(16'h0001, 16'h0207);
        poke(16'h01FD, 16'hAAAA); poke(16'h01FB, 16'hBBBB);
        poke(16'h01FE, 16'hCCCC); poke(16'h01FC, 16'hDDDD); poke(16'h01FF, 16'hEEEE);
        do_reset(16'h0200);
        buf_base = 16'h0100;
        run_tick(1'b1, 11'd2, 16'h4321); settle(8);
        check("B_nacc", acc_q.size(), 5);
        chk_acc("B_wr", 0, 1'b1, 16'h0200, 1);
        chk_acc("B_c0", 1, 1'b0, 16'h0000, 2);
        chk_acc("B_s0", 2, 1'b0, 16'h01FD, 3);
        chk_acc("B_c1", 3, 1'b0, 16'h0001, 4);
        chk_acc("B_s1", 4, 1'b0, 16'h01FB, 5);
        chk_tap("B_t0", 0, 4, 16'hAAAA, 8'h05);
        chk_tap("B_t1", 1, 6, 16'hBBBB, 8'h07);
        chk_fd("B_fd", 6);

        // Memory stalls three cycles in COEF0 (newest 0x0201)
        run_tick(1'b1, 11'd2, 16'h0000);
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("D_hold", {mem_req, mem_we, mem_addr}, {14'd0, 1'b1, 1'b0, 16'h0000});
            @(negedge clk);
        end
        mem_ready = 1'b1;
        settle(6);
        check("D_nacc", acc_q.size(), 5);
        chk_acc("D_c0", 1, 1'b0, 16'h0000, 5);
        chk_tap("D_t0", 0, 7, 16'hCCCC, 8'h05);
        chk_tap("D_t1", 1, 9, 16'hDDDD, 8'h07);
        chk_fd("D_fd", 9);

        // Tick during SAMP0 (newest 0x0202)
        run_tick(1'b1, 11'd2, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("E_ovr_pulse", overrun, 1);
        settle(10);
        check("E_ov_n", ov_q.size(), 1);
        check("E_nacc", acc_q.size(), 5);
        chk_tap("E_t0", 0, 4, 16'hEEEE, 8'h05);
        chk_tap("E_t1", 1, 6, 16'hAAAA, 8'h07);
        chk_fd("E_fd", 6);

        // No-record frame: newest is the last written 0x0202, pointer frozen
        run_tick(1'b0, 11'd1, 16'h9999); settle(6);
        check("F_nacc", acc_q.size(), 2);
        chk_acc("F_c0", 0, 1'b0, 16'h0000, 1);
        chk_acc("F_s0", 1, 1'b0, 16'h01FF, 2);
        chk_tap("F_t0", 0, 3, 16'hEEEE, 8'h05);
        chk_fd("F_fd", 3);
        run_tick(1'b1, 11'd0, 16'h7777); settle(4);
        chk_acc("F_wr", 0, 1'b1, 16'h0203, 1);

        // Pointer wrap at top of memory
        do_reset(16'hFFFF);
        buf_base = 16'h0100;
        run_tick(1'b1, 11'd0, 16'h5A5A); settle(4);
        chk_acc("C_wr_top", 0, 1'b1, 16'hFFFF, 1);
        poke(16'h0000, 16'h0105);
        run_tick(1'b1, 11'd1, 16'h6B6B); settle(6);
        chk_acc("C_wr_base", 0, 1'b1, 16'h0100, 1);
        chk_acc("C_s0", 2, 1'b0, 16'hFFFF, 3);
        chk_tap("C_t0", 0, 4, 16'h5A5A, 8'h05);
        chk_fd("C_fd", 4);

        // Reset in the middle of SAMP0
        do_reset(16'h0100);
        run_tick(1'b1, 11'd2, 16'h2222);
        @(negedge clk);
        @(negedge clk);
        check("G_samp_addr", {mem_req, mem_we, mem_addr}, {14'd0, 1'b1, 1'b0, 16'hFFFF});
        rst = 1'b1;
        @(negedge clk);
        check("G_abort", {mem_req, tap_valid, frame_done}, 32'h0);
        rst = 1'b0;
        settle(8);
        check("G_nfd", fd_q.size(), 0);
        check("G_nacc", acc_q.size(), 3);
        check("G_ntap", tap_q.size(), 0);
        run_tick(1'b1, 11'd0, 16'h3333); settle(4);
        chk_acc("G_wr", 0, 1'b1, 16'h0100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
